// File: rtl/conv_enc_322_feeder_pkg.sv
// Shared constants for the rate-2/3, 8-state (3,2,2) encoder feeding eVITERBI_322.
// The decoder derives its branch labels from the same tap masks.
package conv_enc_322_feeder_pkg;

   localparam int N = 3;   // coded bits per symbol
   localparam int K = 2;   // info bits per symbol

   // Tap masks over {u1,u0,s2,s1,s0}
   localparam logic [4:0] G2 = 5'b11011;
   localparam logic [4:0] G1 = 5'b01110;
   localparam logic [4:0] G0 = 5'b10101;

   localparam logic [3:0] WARMUP_SYMS = 4'd9;
   localparam logic [3:0] HOLD_WARM   = 4'd3;
   localparam logic [3:0] HOLD_STEADY = 4'd13;
   localparam logic [1:0] TAIL_LEN    = 2'd2;
   localparam logic [3:0] SYM_SAT     = 4'd10;   // WARMUP_SYMS + 1

   // Feeder FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HOLD = 2'd1;
   localparam logic [1:0] ST_TAIL = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   function automatic logic parity5(input logic [4:0] v);
      return ^v;
   endfunction

   // Coded symbol for info pair u leaving trellis state s = {s2,s1,s0}
   function automatic logic [2:0] encode_sym(input logic [1:0] u, input logic [2:0] s);
      logic [4:0] v;
      v = {u, s};
      return {parity5(G2 & v), parity5(G1 & v), parity5(G0 & v)};
   endfunction

   // The first WARMUP_SYMS symbols only need the ACS cadence; later ones cover traceback
   function automatic logic [3:0] hold_for(input logic [3:0] sym);
      if (sym <= WARMUP_SYMS) begin
         return HOLD_WARM;
      end else begin
         return HOLD_STEADY;
      end
   endfunction

endpackage

// File: rtl/conv_enc_322_core.sv
// Encoder core: 3-bit trellis state plus the registered coded symbol.
// load advances the trellis by one pair; clr returns it to state 0 with Rx=0.
module conv_enc_322_core
   import conv_enc_322_feeder_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         load,
   input  logic [K-1:0] u,
   output logic [N-1:0] rx
);

   logic [2:0]   state_r;
   logic [N-1:0] rx_r;

   // Symbol is computed from the current state; the state advances on the same edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r <= 3'b000;
         rx_r    <= 3'b000;
      end else if (clr) begin
         state_r <= 3'b000;
         rx_r    <= 3'b000;
      end else if (load) begin
         rx_r    <= encode_sym(u, state_r);
         state_r <= {u[1], state_r[0], u[0]};
      end else begin
         state_r <= state_r;
         rx_r    <= rx_r;
      end
   end

   assign rx = rx_r;

endmodule

// File: rtl/conv_enc_322_feeder.sv
// Feeder for eVITERBI_322: accepts info pairs over valid/ready, holds each coded
// symbol for the decoder's cadence and flushes the trellis with zero tail pairs.
module conv_enc_322_feeder
   import conv_enc_322_feeder_pkg::*;
(
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [K-1:0] in_bits,
   input  logic         in_last,
   output logic         in_ready,
   output logic [N-1:0] Rx,
   output logic         seq_ready,
   output logic         underrun
);

   logic [1:0] state_r;
   logic [3:0] hold_cnt_r;
   logic [1:0] tail_cnt_r;
   logic [3:0] sym_cnt_r;
   logic       last_taken_r;
   logic       seq_ready_r;
   logic       underrun_r;
   logic       in_ready_r;

   logic [1:0]   state_nxt_s;
   logic [3:0]   hold_nxt_s;
   logic [1:0]   tail_nxt_s;
   logic [3:0]   sym_nxt_s;
   logic [3:0]   sym_inc_s;
   logic         last_nxt_s;
   logic         seq_nxt_s;
   logic         underrun_nxt_s;
   logic         in_ready_nxt_s;
   logic         accept_s;
   logic         load_s;
   logic         clr_s;
   logic [K-1:0] u_s;

   conv_enc_322_core u_core (
      .clock (clock),
      .reset (reset),
      .clr   (clr_s),
      .load  (load_s),
      .u     (u_s),
      .rx    (Rx)
   );

   // Next-state decode for the FSM, counters and handshake
   always_comb begin
      state_nxt_s    = state_r;
      hold_nxt_s     = hold_cnt_r;
      tail_nxt_s     = tail_cnt_r;
      sym_nxt_s      = sym_cnt_r;
      last_nxt_s     = last_taken_r;
      seq_nxt_s      = seq_ready_r;
      underrun_nxt_s = underrun_r;
      load_s         = 1'b0;
      clr_s          = 1'b0;
      u_s            = 2'b00;
      accept_s       = in_valid & in_ready_r;
      if (sym_cnt_r >= SYM_SAT) begin
         sym_inc_s = sym_cnt_r;
      end else begin
         sym_inc_s = sym_cnt_r + 4'd1;
      end

      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               load_s      = 1'b1;
               u_s         = in_bits;
               seq_nxt_s   = 1'b1;
               sym_nxt_s   = 4'd1;
               hold_nxt_s  = hold_for(4'd1);
               last_nxt_s  = in_last;
               state_nxt_s = ST_HOLD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_r > 4'd1) begin
               hold_nxt_s = hold_cnt_r - 4'd1;
            end else if (last_taken_r) begin
               // Frame data exhausted: start flushing with zero pairs
               load_s      = 1'b1;
               u_s         = 2'b00;
               tail_nxt_s  = TAIL_LEN - 2'd1;
               sym_nxt_s   = sym_inc_s;
               hold_nxt_s  = hold_for(sym_inc_s);
               state_nxt_s = ST_TAIL;
            end else if (accept_s) begin
               load_s     = 1'b1;
               u_s        = in_bits;
               sym_nxt_s  = sym_inc_s;
               hold_nxt_s = hold_for(sym_inc_s);
               last_nxt_s = in_last;
            end else begin
               // Source starved mid-frame: keep Rx and wait with ready held high
               underrun_nxt_s = 1'b1;
               hold_nxt_s     = 4'd1;
            end
         end
         ST_TAIL: begin
            if (hold_cnt_r > 4'd1) begin
               hold_nxt_s = hold_cnt_r - 4'd1;
            end else if (tail_cnt_r != 2'd0) begin
               load_s     = 1'b1;
               u_s        = 2'b00;
               tail_nxt_s = tail_cnt_r - 2'd1;
               sym_nxt_s  = sym_inc_s;
               hold_nxt_s = hold_for(sym_inc_s);
            end else begin
               // Last tail symbol expired: drop the frame on this edge
               clr_s       = 1'b1;
               seq_nxt_s   = 1'b0;
               sym_nxt_s   = 4'd0;
               hold_nxt_s  = 4'd0;
               last_nxt_s  = 1'b0;
               state_nxt_s = ST_DONE;
            end
         end
         ST_DONE: begin
            clr_s       = 1'b1;
            seq_nxt_s   = 1'b0;
            sym_nxt_s   = 4'd0;
            state_nxt_s = ST_IDLE;
         end
         default: begin
            clr_s       = 1'b1;
            seq_nxt_s   = 1'b0;
            sym_nxt_s   = 4'd0;
            hold_nxt_s  = 4'd0;
            tail_nxt_s  = 2'd0;
            last_nxt_s  = 1'b0;
            state_nxt_s = ST_IDLE;
         end
      endcase

      // Ready is registered, so derive it from the state being entered
      if (state_nxt_s == ST_IDLE) begin
         in_ready_nxt_s = 1'b1;
      end else if ((state_nxt_s == ST_HOLD) && (hold_nxt_s == 4'd1) && !last_nxt_s) begin
         in_ready_nxt_s = 1'b1;
      end else begin
         in_ready_nxt_s = 1'b0;
      end
   end

   // Control and status registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r      <= ST_IDLE;
         hold_cnt_r   <= 4'd0;
         tail_cnt_r   <= 2'd0;
         sym_cnt_r    <= 4'd0;
         last_taken_r <= 1'b0;
         seq_ready_r  <= 1'b0;
         underrun_r   <= 1'b0;
         in_ready_r   <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         hold_cnt_r   <= hold_nxt_s;
         tail_cnt_r   <= tail_nxt_s;
         sym_cnt_r    <= sym_nxt_s;
         last_taken_r <= last_nxt_s;
         seq_ready_r  <= seq_nxt_s;
         underrun_r   <= underrun_nxt_s;
         in_ready_r   <= in_ready_nxt_s;
      end
   end

   assign in_ready  = in_ready_r;
   assign seq_ready = seq_ready_r;
   assign underrun  = underrun_r;

endmodule

// File: tb/tb_conv_enc_322_feeder.sv
// Directed bench for conv_enc_322_feeder: per-cycle Rx traces are compared
// against hand-computed symbol/hold sequences.
module tb_conv_enc_322_feeder;

   logic       clock;
   logic       reset;
   logic       in_valid;
   logic [1:0] in_bits;
   logic       in_last;
   logic       in_ready;
   logic [2:0] Rx;
   logic       seq_ready;
   logic       underrun;

   int errors = 0;
   int checks = 0;

   logic [1:0] pairs [0:15];
   int         n_pairs;
   int         gap_after;
   int         gap_len;
   logic [2:0] exp_q[$];
   logic [2:0] rx_trace[$];
   int         ready_pulses;

   conv_enc_322_feeder dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_bits   (in_bits),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .Rx        (Rx),
      .seq_ready (seq_ready),
      .underrun  (underrun)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Independent encoder equations written out from the tap masks
   function automatic logic [2:0] model_sym(input logic [1:0] u, input logic [2:0] s);
      return {u[1] ^ u[0] ^ s[1] ^ s[0], u[0] ^ s[2] ^ s[1], u[1] ^ s[2] ^ s[0]};
   endfunction

   task automatic add_sym(input logic [2:0] sym, input int len);
      for (int i = 0; i < len; i++) exp_q.push_back(sym);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive pairs[0..n_pairs-1], record Rx while seq_ready is high
   task automatic run_frame(input string tag, input int abort_at);
      int idx;
      int gap_left;
      int cyc;
      bit started;
      bit done;
      bit acc;
      idx = 0; gap_left = 0; cyc = 0; started = 0; done = 0;
      rx_trace.delete();
      ready_pulses = 0;
      while (!done && cyc < 1000) begin
         if (gap_left > 0) begin
            in_valid = 1'b0; in_last = 1'b0; gap_left--;
         end else if (idx < n_pairs) begin
            in_valid = 1'b1; in_bits = pairs[idx]; in_last = (idx == n_pairs - 1);
         end else begin
            in_valid = 1'b0; in_last = 1'b0; in_bits = 2'b00;
         end
         acc = in_valid && in_ready;
         if (in_ready && seq_ready) ready_pulses++;
         tick();
         cyc++;
         if (acc) begin
            idx++;
            if (idx == gap_after) gap_left = gap_len;
         end
         if (seq_ready) begin
            started = 1;
            rx_trace.push_back(Rx);
         end else if (started) begin
            done = 1;
            check_val({tag, " rx_after"}, Rx, 32'd0);
         end
         if (abort_at > 0 && cyc == abort_at) done = 1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check_val({tag, " finished"}, done, 32'd1);
   endtask

   task automatic compare_trace(input string tag);
      int n;
      check_val({tag, " len"}, rx_trace.size(), exp_q.size());
      n = (rx_trace.size() < exp_q.size()) ? rx_trace.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_val($sformatf("%s rx[%0d]", tag, i), rx_trace[i], exp_q[i]);
      end
      exp_q.delete();
   endtask

   initial begin
      logic [2:0] s;
      logic [1:0] u;
      int v;
      reset = 1'b0; in_valid = 1'b0; in_bits = 2'b00; in_last = 1'b0;
      gap_after = -1; gap_len = 0;

      // 1: reset values, then idle
      #3;
      check_val("rst Rx", Rx, 32'd0);
      check_val("rst seq_ready", seq_ready, 32'd0);
      check_val("rst in_ready", in_ready, 32'd0);
      check_val("rst underrun", underrun, 32'd0);
      #19 reset = 1'b1;
      tick(); tick();
      check_val("idle seq_ready", seq_ready, 32'd0);
      check_val("idle in_ready", in_ready, 32'd1);
      check_val("idle Rx", Rx, 32'd0);

      // 2: {01},{00,last}
      pairs[0] = 2'b01; pairs[1] = 2'b00; n_pairs = 2;
      add_sym(3'b110, 3); add_sym(3'b101, 3); add_sym(3'b110, 3); add_sym(3'b000, 3);
      run_frame("f2", 0);
      compare_trace("f2");
      check_val("f2 ready_pulses", ready_pulses, 32'd1);
      check_val("f2 underrun", underrun, 32'd0);

      // 3: single pair {10,last}
      pairs[0] = 2'b10; n_pairs = 1;
      add_sym(3'b101, 3); add_sym(3'b011, 3); add_sym(3'b000, 3);
      run_frame("f3", 0);
      compare_trace("f3");

      // 4: 12 pairs back to back, warm-up then steady hold
      n_pairs = 12;
      s = 3'b000;
      for (int k = 1; k <= 14; k++) begin
         if (k <= 12) begin
            v = k * 3 + 1;
            pairs[k-1] = v[1:0];
            u = v[1:0];
         end else begin
            u = 2'b00;
         end
         add_sym(model_sym(u, s), (k <= 9) ? 3 : 13);
         s = {u[1], s[0], u[0]};
      end
      run_frame("f4", 0);
      compare_trace("f4");
      check_val("f4 ready_pulses", ready_pulses, 32'd11);
      check_val("f4 underrun", underrun, 32'd0);

      // 5: valid dropped for 5 cycles after pair 2
      pairs[0] = 2'b01; pairs[1] = 2'b00; pairs[2] = 2'b10; n_pairs = 3;
      gap_after = 2; gap_len = 5;
      add_sym(3'b110, 3); add_sym(3'b101, 6); add_sym(3'b011, 3);
      add_sym(3'b011, 3); add_sym(3'b000, 3);
      run_frame("f5", 0);
      compare_trace("f5");
      check_val("f5 underrun", underrun, 32'd1);
      gap_after = -1; gap_len = 0;
      tick(); tick(); tick();
      check_val("f5 underrun sticky", underrun, 32'd1);

      // 6: reset during the tail of the {01},{00,last} frame
      pairs[0] = 2'b01; pairs[1] = 2'b00; n_pairs = 2;
      add_sym(3'b110, 3); add_sym(3'b101, 3); add_sym(3'b110, 2);
      run_frame("f6a", 8);
      compare_trace("f6a");
      #2 reset = 1'b0;
      #1;
      check_val("f6 rst Rx", Rx, 32'd0);
      check_val("f6 rst seq_ready", seq_ready, 32'd0);
      check_val("f6 rst in_ready", in_ready, 32'd0);
      check_val("f6 rst underrun", underrun, 32'd0);
      #3 reset = 1'b1;
      tick();
      pairs[0] = 2'b10; n_pairs = 1;
      add_sym(3'b101, 3); add_sym(3'b011, 3); add_sym(3'b000, 3);
      run_frame("f6b", 0);
      compare_trace("f6b");
      check_val("f6 underrun", underrun, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
